// File: rtl/deck_shuffler.sv
// Card source for the blackjack game: fills a 52-card deck, shuffles it in
// place with an LFSR-driven Fisher-Yates pass, then deals one card per request.
module deck_shuffler #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int          DECK_SIZE    = 52,
  parameter int          RANKS        = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic        draw_req,
  output logic [3:0]  card,
  output logic        card_valid,
  output logic        ready,
  output logic        busy,
  output logic        deck_empty,
  output logic [5:0]  deck_pos,
  output logic [5:0]  cards_left
);

  localparam logic [5:0]  LAST_IDX  = 6'(DECK_SIZE - 1);
  localparam logic [5:0]  FULL_DECK = 6'(DECK_SIZE);
  localparam logic [3:0]  TOP_RANK  = 4'(RANKS);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHUFFLE,
    READY,
    EMPTY
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [15:0] seed_eff;
  logic [5:0]  idx;
  logic [5:0]  mask;
  logic [5:0]  j_sel;
  logic [3:0]  rank;
  logic        accept;
  logic        fill_we;
  logic        swap_we;
  logic [3:0]  deck [DECK_SIZE];

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Smallest all-ones value that covers index i, so a masked draw is in 0..mask.
  function automatic logic [5:0] mask_for(input logic [5:0] i);
    if (i > 6'd31)      mask_for = 6'd63;
    else if (i > 6'd15) mask_for = 6'd31;
    else if (i > 6'd7)  mask_for = 6'd15;
    else if (i > 6'd3)  mask_for = 6'd7;
    else if (i > 6'd1)  mask_for = 6'd3;
    else                mask_for = 6'd1;
  endfunction

  // Candidate swap partner and write enables; start pre-empts any deck write.
  always_comb begin
    lfsr_next = lfsr_step(lfsr);
    mask      = mask_for(idx);
    j_sel     = lfsr_next[5:0] & mask;
    accept    = (j_sel <= idx);
    fill_we   = (state == FILL) && !start;
    swap_we   = (state == SHUFFLE) && accept && !start;
    seed_eff  = (seed == 16'h0000) ? SEED_DEFAULT : seed;
  end

  // Deck storage: filled sequentially, then permuted by swaps (contents not reset).
  always_ff @(posedge clk) begin
    if (fill_we) begin
      deck[idx] <= rank;
    end else if (swap_we) begin
      deck[idx]   <= deck[j_sel];
      deck[j_sel] <= deck[idx];
    end
  end

  // Control FSM with registered status flags and dealt card.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= SEED_DEFAULT;
      idx        <= 6'd0;
      rank       <= 4'd1;
      deck_pos   <= 6'd0;
      card       <= 4'd0;
      card_valid <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      deck_empty <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      if (start) begin
        state      <= FILL;
        lfsr       <= seed_eff;
        idx        <= 6'd0;
        rank       <= 4'd1;
        deck_pos   <= 6'd0;
        ready      <= 1'b0;
        busy       <= 1'b1;
        deck_empty <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (idx == LAST_IDX) begin
              state <= SHUFFLE;
            end else begin
              idx  <= idx + 6'd1;
              rank <= (rank == TOP_RANK) ? 4'd1 : rank + 4'd1;
            end
          end
          SHUFFLE: begin
            lfsr <= lfsr_next;
            if (accept) begin
              if (idx == 6'd1) begin
                state <= READY;
                busy  <= 1'b0;
                ready <= 1'b1;
              end else begin
                idx <= idx - 6'd1;
              end
            end
          end
          READY: begin
            if (draw_req) begin
              card       <= deck[deck_pos];
              card_valid <= 1'b1;
              deck_pos   <= deck_pos + 6'd1;
              if (deck_pos == LAST_IDX) begin
                state      <= EMPTY;
                ready      <= 1'b0;
                deck_empty <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign cards_left = FULL_DECK - deck_pos;

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
- Upstream card source for the blackjack game FSM.
- Builds a 52-card deck and shuffles it in place with a Fisher-Yates pass driven by an internal LFSR.
- Serves cards one at a time on request, using a 1-cycle request/valid handshake.
- Replaces the game FSM's internal deck array and position counter; the game consumes `card` and `card_valid` directly.

Parameters:
- SEED_DEFAULT, 16'hACE1, LFSR seed used when the `seed` input is zero at start.
- DECK_SIZE, 52, number of cards; fixed at 52, parameter exists for documentation only.
- RANKS, 13, ranks per suit; card codes are 1..13 (A=1, 2..10, J=11, Q=12, K=13).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle pulse; (re)build and shuffle the deck.
- seed, input, 16, LFSR seed, sampled on the cycle `start` is high.
- draw_req, input, 1, request one card; honoured only in READY.
- card, output, 4, dealt card code (1..13); holds its last value between draws.
- card_valid, output, 1, one-cycle pulse marking `card` as new.
- ready, output, 1, high in READY.
- busy, output, 1, high in FILL or SHUFFLE.
- deck_empty, output, 1, high in EMPTY.
- deck_pos, output, 6, index of the next card to deal (0..52).
- cards_left, output, 6, equals 52 − deck_pos.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, card=0, card_valid=0, ready=0, busy=0, deck_empty=0, deck_pos=0, cards_left=52.
  - LFSR=SEED_DEFAULT; deck contents don't care.
- States: IDLE, FILL, SHUFFLE, READY, EMPTY.
- start:
  - Accepted in every state and takes priority over `draw_req` in the same cycle.
  - LFSR loads `seed` (SEED_DEFAULT if `seed`==0), index counter loads 0, deck_pos loads 0, next state is FILL.
  - A start during FILL or SHUFFLE aborts and restarts cleanly.
- FILL: one card per cycle, 52 cycles.
  - deck[k] = (k mod 13) + 1 for k=0..51.
  - After writing k=51, load i=51 and enter SHUFFLE.
- SHUFFLE: one LFSR step per cycle.
  - LFSR is a 16-bit Galois LFSR, shift right; if bit0 was 1, XOR with 16'hB400.
  - j = lfsr_next[5:0] & mask(i), where mask(i) is the smallest 2^n−1 that is ≥ i.
  - If j > i: reject; i is unchanged.
  - Otherwise: swap deck[i] and deck[j] (j==i is a legal no-op swap), then i = i−1.
  - When i==1 is accepted, enter READY the next cycle.
  - LFSR advances only in SHUFFLE.
  - Latency is variable but deterministic for a given seed.
- READY:
  - When draw_req=1 at a clock edge, the next cycle has card=deck[deck_pos], card_valid=1, and deck_pos increments.
  - draw_req held high deals one card per cycle.
  - When the 52nd card is dealt (deck_pos becomes 52), move to EMPTY in the same edge; card_valid for that card still pulses.
- EMPTY: deck_empty=1 and ready=0; draw_req is ignored (card_valid stays 0, card holds). Only start or reset leaves EMPTY.
- draw_req in IDLE, FILL or SHUFFLE is ignored; it is not queued.
- cards_left is always 52 − deck_pos. Output widths are exact; deck_pos never exceeds 52.
- Invariant: after SHUFFLE, the deck is a permutation of the filled deck, i.e. each code 1..13 appears exactly 4 times.

Test Plan:
- Reset check: hold reset=0 mid-run → all outputs at reset values (cards_left=52, card_valid=0, ready=0, busy=0) immediately, without waiting for a clock edge.
- Permutation check: start with seed=16'h1234, wait for ready (timeout 2000 cycles), draw 52 cards → every code 1..13 seen exactly 4 times; deck_pos=52; deck_empty=1 on the cycle after the last card_valid.
- Reproducibility: run twice with seed=16'h1234 → identical 52-card sequences. Run with seed=0 and seed=16'hACE1 → identical sequences. Run with seed=16'h0001 → the sequence differs from the seed=16'h1234 run.
- Handshake: in READY pulse draw_req for 1 cycle → exactly one card_valid pulse next cycle, deck_pos +1. Hold draw_req for 5 cycles → 5 consecutive pulses, cards_left drops by 5. draw_req in EMPTY → no card_valid pulse.
- Priority and abort: assert start together with draw_req in READY → no card_valid pulse, busy=1 next cycle, deck_pos=0. Assert start mid-SHUFFLE → FILL restarts; the resulting sequence matches a clean run with the same seed.
- Reset mid-operation: reset=0 during SHUFFLE, release, then start with seed=16'h1234 → sequence identical to the reference run.
